// File: rtl/floating_division.sv
// Iterative binary32 divider: restoring radix-2 division producing one
// quotient bit per clock, then a single normalize/pack cycle. Truncating
// mantissa policy, denormals treated as zero, start/busy/done handshake.
module floating_division #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_NORM   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'd24;

  state_t r_state;
  state_t w_next;

  logic [4:0]      r_count;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [24:0]     r_rem;
  logic [24:0]     r_quo;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic            r_ovf;
  logic            r_unf;
  logic            r_exc;

  // Restoring step: trial-subtract the divisor from the partial remainder.
  logic [23:0] w_mb;
  logic [25:0] w_diff;
  logic        w_ge;
  logic [24:0] w_rem_kept;

  assign w_mb       = {1'b1, r_b[22:0]};
  assign w_diff     = {1'b0, r_rem} - {2'b00, w_mb};
  assign w_ge       = ~w_diff[25];
  // The kept remainder is always below the divisor, so bit 24 is zero and
  // the left shift below cannot lose information.
  assign w_rem_kept = w_ge ? w_diff[24:0] : r_rem;

  // Operand classification on the latched operands.
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;

  assign w_a_zero = (r_a[30:23] == 8'h00);
  assign w_b_zero = (r_b[30:23] == 8'h00);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_sign   = r_a[31] ^ r_b[31];

  // Normalization: a quotient below 1.0 needs one left shift and exponent -1.
  logic              w_adj;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp;

  assign w_adj  = ~r_quo[24];
  assign w_frac = r_quo[24] ? r_quo[23:1] : r_quo[22:0];
  assign w_exp  = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]})
                + 10'sd127 - $signed({9'd0, w_adj});

  logic [XLEN-1:0] w_result;
  logic            w_ovf;
  logic            w_unf;
  logic            w_exc;

  // Pack result and flags with special-operand priority (first match wins).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_result = {w_sign, w_exp[7:0], w_frac};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_exc    = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_result = 32'h7FC0_0000;
      w_exc    = 1'b1;
    end else if (w_a_inf || w_b_zero) begin
      w_result = {w_sign, 8'hFF, 23'd0};
      w_exc    = 1'b1;
    end else if (w_b_inf) begin
      w_result = {w_sign, 31'd0};
      w_exc    = 1'b1;
    end else if (w_a_zero) begin
      w_result = {w_sign, 31'd0};
    end else if (w_exp >= 10'sd255) begin
      w_result = {w_sign, 8'hFF, 23'd0};
      w_ovf    = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_result = {w_sign, 31'd0};
      w_unf    = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: accept start in IDLE, 25 divide steps, one pack cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DIVIDE;
      S_DIVIDE: if (r_count == LAST_BIT) w_next = S_NORM;
      S_NORM:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, restoring iteration, result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= 5'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_exc    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_rem   <= {2'b01, A[22:0]};
            r_quo   <= '0;
            r_count <= 5'd0;
            r_busy  <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_exc   <= 1'b0;
          end
        end
        S_DIVIDE: begin
          r_rem   <= {w_rem_kept[23:0], 1'b0};
          r_quo   <= {r_quo[23:0], w_ge};
          r_count <= r_count + 5'd1;
        end
        S_NORM: begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_exc    <= w_exc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exception = r_exc;

endmodule

// File: tb/tb_floating_division.sv
// Self-checking bench for floating_division: directed cases, handshake and
// reset scenarios, then randomized operands against an arithmetic model.
module tb_floating_division;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, overflow, underflow, exception;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  floating_division dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, underflow, exception, result} from field arithmetic.
  function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int unsigned       ea, eb, fa, fb;
    bit                s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint unsigned   q;
    int                e;
    logic [22:0]       frac;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    s = a[31] ^ b[31];
    a_zero = (ea == 0); b_zero = (eb == 0);
    a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
    a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
    q = ((64'd8388608 + longint'(fa)) * 64'd16777216) / (64'd8388608 + longint'(fb));
    if (q >= 64'd16777216) begin
      frac = 23'((q / 2) % 64'd8388608);
      e = int'(ea) - int'(eb) + 127;
    end else begin
      frac = 23'(q % 64'd8388608);
      e = int'(ea) - int'(eb) + 126;
    end
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {3'b001, 32'h7FC00000};
    if (a_inf || b_zero) return {3'b001, s, 8'hFF, 23'd0};
    if (b_inf)           return {3'b001, s, 31'd0};
    if (a_zero)          return {3'b000, s, 31'd0};
    if (e >= 255)        return {3'b100, s, 8'hFF, 23'd0};
    if (e <= 0)          return {3'b010, s, 31'd0};
    return {3'b000, s, e[7:0], frac};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  // Counts edges from acceptance until done, bounded; optional stray starts.
  task automatic wait_done(input bit inject, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      if (inject && (lat == 4 || lat == 19)) begin
        start = 1'b1; A = 32'h3F800000; B = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input logic [34:0] exp, input int lat, input int bcnt);
    check({tag, ".latency"}, 32'(lat), 32'd26);
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'd26);
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, ".result"}, result, exp[31:0]);
    check({tag, ".flags"}, {29'd0, overflow, underflow, exception}, {29'd0, exp[34:32]});
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [34:0] exp);
    int lat, bcnt;
    launch(a, b);
    wait_done(1'b0, lat, bcnt);
    verify(tag, exp, lat, bcnt);
    tick();
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, bcnt, done_seen;
    logic [31:0] ra, rb;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset.result", result, 32'd0);
    check("reset.ctrl", {28'd0, busy, done, overflow, underflow}, 32'd0);
    check("reset.exc", {31'd0, exception}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_check("six_by_two",  32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});
    run_check("one_third",   32'h3F800000, 32'h40400000, {3'b000, 32'h3EAAAAAA});
    run_check("neg_7p5",     32'hC0F00000, 32'h40200000, {3'b000, 32'hC0400000});
    run_check("div_by_zero", 32'h3F800000, 32'h00000000, {3'b001, 32'h7F800000});
    run_check("zero_zero",   32'h00000000, 32'h00000000, {3'b001, 32'h7FC00000});
    run_check("zero_num",    32'h00000000, 32'h40000000, {3'b000, 32'h00000000});
    run_check("overflow",    32'h7F000000, 32'h3F000000, {3'b100, 32'h7F800000});
    run_check("underflow",   32'h00800000, 32'h7F000000, {3'b010, 32'h00000000});
    run_check("inf_inf",     32'h7F800000, 32'hFF800000, {3'b001, 32'h7FC00000});
    run_check("num_inf",     32'hBF800000, 32'h7F800000, {3'b001, 32'h80000000});

    // Stray starts during an op are ignored; start in the done cycle is taken.
    launch(32'h3F800000, 32'h40400000);
    wait_done(1'b1, lat, bcnt);
    verify("ignore_start", {3'b000, 32'h3EAAAAAA}, lat, bcnt);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    tick();
    start = 1'b0; A = $urandom; B = $urandom;
    check("b2b.done_cleared", {31'd0, done}, 32'd0);
    check("b2b.busy_set", {31'd0, busy}, 32'd1);
    wait_done(1'b0, lat, bcnt);
    verify("b2b", {3'b000, 32'h40400000}, lat, bcnt);
    tick();

    // Reset in the middle of DIVIDE aborts without a done.
    launch(32'h7F000000, 32'h3F000000);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check("midreset.result", result, 32'd0);
    check("midreset.ctrl", {27'd0, busy, done, overflow, underflow, exception}, 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("midreset.no_done", 32'(done_seen), 32'd0);
    run_check("after_reset", 32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});

    // Randomized operands, with occasional special exponents.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra[30:23] = 8'hFF;
        1: rb[30:23] = 8'hFF;
        2: ra[30:23] = 8'h00;
        3: rb[30:23] = 8'h00;
        4: begin ra[30:23] = 8'hFE; rb[30:23] = 8'h01; end
        5: begin ra[30:23] = 8'h01; rb[30:23] = 8'hFE; end
        default: begin
          ra[30:23] = 8'(64 + $urandom_range(0, 127));
          rb[30:23] = 8'(64 + $urandom_range(0, 127));
        end
      endcase
      run_check($sformatf("rand%0d", i), ra, rb, ref_div(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
